// File: rtl/wb_arbiter_2to1_pkg.sv
// Shared types for the two-master Wishbone B3 frame-buffer arbiter:
// FSM state encoding, bundled request/response records and widths.
package wb_arb;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M0 = 2'd1,
        GRANT_M1 = 2'd2
    } ArbState;

    localparam int WD_W  = 16;
    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic [2:0]       cti;
        logic [1:0]       bte;
    } WbReq;

    typedef struct packed {
        logic ack;
        logic err;
        logic rty;
    } WbRsp;

    // One-hot owner vector: bit 0 is the display master, bit 1 the CPU.
    function automatic logic [1:0] grantOf(input ArbState st);
        logic [1:0] g;
        g = 2'b00;
        case (st)
            GRANT_M0: g = 2'b01;
            GRANT_M1: g = 2'b10;
            default:  g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_arbiter_2to1_watchdog.sv
// Per-beat stall watchdog: counts cycles a granted strobe waits for a slave
// response and flags the cycle in which the configured limit is reached.
module wb_watchdog
    import wb_arb::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            run,
    input  logic [WD_W-1:0] limit,
    output logic            fire
);

    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;

    // A response (folded into clear) in the firing cycle always wins.
    assign fire = !rst && run && !clear && (wd_q == limit - WD_W'(1));

    always_comb begin
        wd_d = wd_q;
        if (clear || fire) begin
            wd_d = '0;
        end else if (run) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Two-master Wishbone B3 arbiter: display DMA (m0) has fixed priority over
// the CPU (m1); an owner keeps the bus until it drops cyc.
module wb_arbiter_2to1
    import wb_arb::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic [2:0]       m0_cti_i,
    input  logic [1:0]       m0_bte_i,
    input  logic             m0_we_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic             m0_rty_o,

    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic [2:0]       m1_cti_i,
    input  logic [1:0]       m1_bte_i,
    input  logic             m1_we_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             m1_rty_o,

    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic [2:0]       s_cti_o,
    output logic [1:0]       s_bte_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i,

    output logic [1:0]       grant,
    output logic             timeout_evt
);

    ArbState state_q;

    WbReq m0Req;
    WbReq m1Req;
    WbReq sReq;
    WbRsp sRsp;
    WbRsp m0Rsp;
    WbRsp m1Rsp;

    logic ownStb;
    logic slaveRsp;
    logic wdClear;
    logic wdFire;

    assign m0Req = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i, adr: m0_adr_i,
                     dat: m0_dat_i, sel: m0_sel_i, cti: m0_cti_i, bte: m0_bte_i};
    assign m1Req = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i, adr: m1_adr_i,
                     dat: m1_dat_i, sel: m1_sel_i, cti: m1_cti_i, bte: m1_bte_i};
    assign sRsp  = '{ack: s_ack_i, err: s_err_i, rty: s_rty_i};

    // No preemption: a release always passes through IDLE before re-arbitrating.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_cyc_i) begin
                        state_q <= GRANT_M0;
                    end else if (m1_cyc_i) begin
                        state_q <= GRANT_M1;
                    end
                end
                GRANT_M0: begin
                    if (!m0_cyc_i) begin
                        state_q <= IDLE;
                    end
                end
                GRANT_M1: begin
                    if (!m1_cyc_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ownStb = 1'b0;
        case (state_q)
            GRANT_M0: ownStb = m0_stb_i;
            GRANT_M1: ownStb = m1_stb_i;
            default:  ownStb = 1'b0;
        endcase
    end

    assign slaveRsp = s_ack_i || s_err_i || s_rty_i;
    assign wdClear  = (state_q == IDLE) || !ownStb || slaveRsp;

    wb_watchdog u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clear (wdClear),
        .run   (ownStb),
        .limit (WD_W'(TIMEOUT)),
        .fire  (wdFire)
    );

    // Reset gating keeps the slave port and master responses quiet even in
    // the first reset cycle, before state_q has returned to IDLE.
    always_comb begin
        sReq  = '0;
        m0Rsp = '0;
        m1Rsp = '0;
        case (state_q)
            IDLE: begin
                sReq = '0;
            end
            GRANT_M0: begin
                sReq      = m0Req;
                m0Rsp     = sRsp;
                m0Rsp.err = s_err_i || wdFire;
            end
            GRANT_M1: begin
                sReq      = m1Req;
                m1Rsp     = sRsp;
                m1Rsp.err = s_err_i || wdFire;
            end
            default: begin
                sReq = '0;
            end
        endcase
        if (wdFire) begin
            sReq.stb = 1'b0;
        end
        if (rst) begin
            sReq  = '0;
            m0Rsp = '0;
            m1Rsp = '0;
        end
    end

    assign s_cyc_o = sReq.cyc;
    assign s_stb_o = sReq.stb;
    assign s_we_o  = sReq.we;
    assign s_adr_o = sReq.adr;
    assign s_dat_o = sReq.dat;
    assign s_sel_o = sReq.sel;
    assign s_cti_o = sReq.cti;
    assign s_bte_o = sReq.bte;

    assign m0_ack_o = m0Rsp.ack;
    assign m0_err_o = m0Rsp.err;
    assign m0_rty_o = m0Rsp.rty;
    assign m1_ack_o = m1Rsp.ack;
    assign m1_err_o = m1Rsp.err;
    assign m1_rty_o = m1Rsp.rty;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign grant       = grantOf(state_q);
    assign timeout_evt = wdFire;

endmodule

// File: doc/wb_arbiter_2to1.md
# wb_arbiter_2to1

Two-master, one-slave Wishbone B3 arbiter that shares the frame-buffer memory bus between the display line-fetch DMA and the CPU. The display master has fixed priority so scanline fills are never starved. Once granted, a master owns the bus for its whole cycle (`cyc` held). A per-beat watchdog terminates a stalled beat with `err`. It sits between the masters and the memory controller's Wishbone slave port.

## Interface
- `TIMEOUT`, default 255: cycles a granted beat may wait with `stb`=1 and no `ack`/`err`/`rty` before the watchdog fires. Range 1..65535.
- `clk` input 1: single system clock, all logic on posedge.
- `rst` input 1: reset, synchronous and active-high.
- `m0` wishbone_b3.slave: high-priority master (display DMA). 32-bit `adr`/`dat`, 4-bit `sel`, `cti`, `bte`, `we`, `cyc`, `stb`, `ack`, `err`, `rty`.
- `m1` wishbone_b3.slave: low-priority master (CPU), same signal set.
- `s` wishbone_b3.master: shared slave (frame-buffer memory), same signal set.
- `grant` output 2: one-hot current owner. Bit 0 is `m0`, bit 1 is `m1`, 00 when idle. Used for debug and perf counters.
- `timeout_evt` output 1: one-cycle pulse when the watchdog fires.

## Operation
- States:
  - IDLE: no owner, `s.cyc`=`s.stb`=0.
  - GRANT_M0: `m0` owns the bus.
  - GRANT_M1: `m1` owns the bus.
- Transitions from IDLE:
  - `m0.cyc`=1 goes to GRANT_M0.
  - Otherwise `m1.cyc`=1 goes to GRANT_M1.
  - If both are requesting, `m0` wins.
- Transitions from GRANT_x:
  - Stay while `mx.cyc`=1.
  - Go to IDLE on the first cycle `mx.cyc`=0.
  - There is no preemption. A long `m0` burst (800 beats per scanline) holds the bus to completion.
- Handover: every release passes through IDLE for at least one cycle. `s.cyc` is low for ≥1 cycle between owners.
- Muxing is combinational from the registered state.
  - Owner's `cyc`, `stb`, `adr`, `dat_m2s`, `we`, `sel`, `cti`, `bte` go to `s`.
  - `s.ack`/`err`/`rty` go to the owner only.
- Non-owner gets `ack`=`err`=`rty`=0. `s.dat_s2m` is broadcast to both masters unmasked.
- In IDLE, `s` outputs are all 0.
- Watchdog:
  - 16-bit counter `wd`.
  - Cleared when state is IDLE, when owner `stb`=0, or when any of `s.ack`/`err`/`rty` is 1.
  - Otherwise increments.
  - When `wd`==TIMEOUT-1 and no slave response arrives that cycle, the arbiter:
    - drives `err`=1 to the owner for exactly that cycle;
    - forces `s.stb`=0 for that cycle;
    - pulses `timeout_evt`;
    - clears `wd`.
  - The arbiter stays in GRANT_x until the master drops `cyc`.
- Simultaneous events:
  - A slave response in the same cycle the watchdog would fire wins. The response is forwarded, `err` is not injected, and `wd` is cleared.
  - `m0.cyc` rising while `m1` owns the bus waits; it is granted on the cycle after IDLE.
- Reset mid-cycle:
  - Next edge gives state IDLE, `wd`=0, and `grant`=00.
  - All `s` outputs and all master responses are 0 while `rst`=1 and on the first cycle after.
  - The aborted slave cycle is not completed.

## Timing
- Reset values: state IDLE, `grant`=00, `timeout_evt`=0, `wd`=0. `s.cyc`/`stb`/`we`/`adr`/`sel`/`cti`/`bte`/`dat_m2s`=0. Master `ack`/`err`/`rty`=0.
- Grant latency: `mx.cyc` sampled high at edge N in IDLE gives `s.cyc`=1 with the owner's signals from cycle N+1.
- Response path `s.ack` to `mx.ack` is zero-latency (combinational). Back-to-back single-cycle acks sustain 1 beat/clk.
- Release: `mx.cyc` low in cycle N gives IDLE in N+1. The next owner appears in N+2 at earliest.
- Watchdog fires in the TIMEOUT-th consecutive stalled cycle of a beat.

## Structure
- Package `wb_arb` holds:
  - `typedef enum logic [1:0] {IDLE, GRANT_M0, GRANT_M1} ArbState`;
  - `localparam WD_W = 16`.
- Sub-module `wb_watchdog`:
  - ports: `clk`, `rst`, `clear`, `run`, `limit`, `fire`;
  - holds `wd`;
  - instantiated once.
- Top holds the state register, priority logic and the output mux (`always_comb`, one case per state).

## Test plan
- Reset: hold `rst` 3 cycles during an active `m1` beat. Then `grant`=00, `s.cyc`=0, and `m1.ack`=0 on the first cycle after reset.
- Priority tie: `m0.cyc` and `m1.cyc` rise together.
  - `grant`=01 next cycle, and `s.adr` follows `m0.adr` (0x02000000).
  - `m1` sees no `ack` until `m0` drops `cyc` after 800 acks.
  - Then 1 IDLE cycle, then `grant`=10.
- No preemption: `m1` single read in progress and `m0.cyc` rises mid-beat.
  - `m1` completes on `s.ack`.
  - `s.cyc` is low for exactly 1 cycle, then `grant`=01.
- Throughput: `m0` 800-beat burst with a slave acking every cycle. Exactly 800 `m0.ack` pulses in 800 consecutive cycles, with addresses incrementing by 4.
- Watchdog, TIMEOUT=4: slave never acks a `m1` beat.
  - `m1.err`=1 and `timeout_evt`=1 in the 4th stalled cycle, with `s.stb`=0 that cycle.
  - `m1` drops `cyc`, then IDLE.
- Watchdog race, TIMEOUT=4: slave acks in the 4th stalled cycle. `m1.ack`=1, `m1.err`=0, `timeout_evt`=0.
